// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed N-digit 7-segment driver with hex decode,
// frame-synchronous shadow registers and optional per-slot anode dead-time.
module display_scan_mux #(
    parameter int DIGITS     = 4,
    parameter int PERIOD     = 100000,
    parameter int BLANK      = 0,
    parameter int ACTIVE_LOW = 1,
    localparam int SEL_W     = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blank,
    output logic [SEL_W-1:0]      digit_sel,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            seg,
    output logic                  frame_done
);
    localparam int PW = $clog2(PERIOD);
    localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW != 0}};
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW != 0}};
    // active-low {dp,g..a} glyphs for 0..F, entry 0 in the low byte
    localparam logic [127:0] HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    logic [PW-1:0]       pre_q, pre_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_point_q, sh_point_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]          seg_q, seg_d;
    logic                fd_q, fd_d;
    logic                tick, wrap, dark;
    logic [3:0]          nib;
    logic [7:0]          glyph;

    always_comb begin
        tick       = en && pre_q == PW'(PERIOD - 1);
        wrap       = tick && sel_q == SEL_W'(DIGITS - 1);
        pre_d      = tick ? '0 : en ? pre_q + 1'b1 : pre_q;
        sel_d      = wrap ? '0 : tick ? sel_q + 1'b1 : sel_q;
        sh_data_d  = wrap ? data : sh_data_q;
        sh_point_d = wrap ? point : sh_point_q;
        sh_blank_d = wrap ? blank : sh_blank_q;
        fd_d       = wrap;
        nib        = sh_data_q[{sel_q, 2'b00} +: 4];
        glyph      = {~sh_point_q[sel_q], HEX[{nib, 3'b000} +: 7]};
        // signed compare keeps BLANK=0 from being a constant unsigned test
        dark       = !en || sh_blank_q[sel_q] || int'(pre_q) < BLANK;
        anode_d    = dark ? AN_OFF : AN_OFF ^ (DIGITS'(1) << sel_q);
        seg_d      = dark ? SEG_OFF : glyph ^ ~SEG_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            sel_q      <= '0;
            sh_data_q  <= '0;
            sh_point_q <= '0;
            sh_blank_q <= '0;
            anode_q    <= AN_OFF;
            seg_q      <= SEG_OFF;
            fd_q       <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sel_q      <= sel_d;
            sh_data_q  <= sh_data_d;
            sh_point_q <= sh_point_d;
            sh_blank_q <= sh_blank_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end

    assign digit_sel  = sel_q;
    assign anode      = anode_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: scoreboarded directed test of four display_scan_mux configurations.
module tb_display_scan_mux;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic        a_en = 1'b1, b_en = 1'b1, c_en = 1'b1, d_en = 1'b1;
    logic [15:0] a_data = 16'h1234, b_data = 16'h1234;
    logic [31:0] c_data = 32'h0;
    logic [3:0]  d_data = 4'h5;
    logic [3:0]  a_point = 4'b0000, b_point = 4'b0001, a_blank = 4'b0000, b_blank = 4'b0010;
    logic [7:0]  c_point = 8'h00, c_blank = 8'h00;
    logic        d_point = 1'b0, d_blank = 1'b0;
    logic [1:0]  a_sel, b_sel;
    logic [2:0]  c_sel;
    logic [0:0]  d_sel;
    logic [3:0]  a_an, b_an;
    logic [7:0]  c_an;
    logic        d_an;
    logic [7:0]  a_seg, b_seg, c_seg, d_seg;
    logic        a_fd, b_fd, c_fd, d_fd;

    display_scan_mux #(.DIGITS(4), .PERIOD(4), .BLANK(0), .ACTIVE_LOW(1)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .data(a_data), .point(a_point), .blank(a_blank),
        .digit_sel(a_sel), .anode(a_an), .seg(a_seg), .frame_done(a_fd));
    display_scan_mux #(.DIGITS(4), .PERIOD(4), .BLANK(1), .ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .data(b_data), .point(b_point), .blank(b_blank),
        .digit_sel(b_sel), .anode(b_an), .seg(b_seg), .frame_done(b_fd));
    display_scan_mux #(.DIGITS(8), .PERIOD(2), .BLANK(0), .ACTIVE_LOW(0)) u_c (
        .clk(clk), .rst(rst), .en(c_en), .data(c_data), .point(c_point), .blank(c_blank),
        .digit_sel(c_sel), .anode(c_an), .seg(c_seg), .frame_done(c_fd));
    display_scan_mux #(.DIGITS(1), .PERIOD(2), .BLANK(0), .ACTIVE_LOW(0)) u_d (
        .clk(clk), .rst(rst), .en(d_en), .data(d_data), .point(d_point), .blank(d_blank),
        .digit_sel(d_sel), .anode(d_an), .seg(d_seg), .frame_done(d_fd));

    always #5 if (run) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         inst;
        logic [7:0] an;
        logic [7:0] sg;
        logic [3:0] sel;
        logic       fd;
    } exp_t;
    exp_t q[$];

    logic [7:0] an4 [4] = '{8'h0E, 8'h0D, 8'h0B, 8'h07};
    logic [7:0] sa2 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] sb2 [4] = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] sb4 [4] = '{8'h21, 8'hC6, 8'h83, 8'h88};

    task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic check_now(int i, logic [7:0] an, logic [7:0] sg, logic [3:0] sel, logic fd, string tag);
        logic [7:0] an_a, sg_a, sel_a, fd_a;
        an_a  = i == 0 ? {4'h0, a_an} : i == 1 ? {4'h0, b_an} : i == 2 ? c_an : {7'h0, d_an};
        sg_a  = i == 0 ? a_seg : i == 1 ? b_seg : i == 2 ? c_seg : d_seg;
        sel_a = i == 0 ? {6'h0, a_sel} : i == 1 ? {6'h0, b_sel} : i == 2 ? {5'h0, c_sel} : {7'h0, d_sel};
        fd_a  = {7'h0, i == 0 ? a_fd : i == 1 ? b_fd : i == 2 ? c_fd : d_fd};
        chk($sformatf("%s i%0d anode", tag, i), an_a, an);
        chk($sformatf("%s i%0d seg", tag, i), sg_a, sg);
        chk($sformatf("%s i%0d digit_sel", tag, i), sel_a, {4'h0, sel});
        chk($sformatf("%s i%0d frame_done", tag, i), fd_a, {7'h0, fd});
    endtask

    task automatic push(int k, int i, logic [7:0] an, logic [7:0] sg, int sel, logic fd);
        exp_t e;
        e.cyc = k; e.inst = i; e.an = an; e.sg = sg; e.sel = 4'(sel); e.fd = fd;
        q.push_back(e);
    endtask

    task automatic expect_cycle(int k);
        int d, f, p, e;
        logic off;
        d = ((k - 1) / 4) % 4;
        f = (k - 1) / 16;
        push(k, 0, an4[d], f == 0 ? 8'hC0 : f == 1 ? sa2[d] : 8'h80, (k / 4) % 4, k % 16 == 0);
        if (k >= 35 && k <= 44) push(k, 1, 8'h0F, 8'hFF, 0, 1'b0);
        else begin
            e = k >= 45 ? k - 10 : k;
            p = (e - 1) % 4;
            d = ((e - 1) / 4) % 4;
            f = (e - 1) / 16;
            off = p == 0 || (f >= 1 && d == 1);
            push(k, 1, off ? 8'h0F : an4[d],
                 off ? 8'hFF : f == 0 ? 8'hC0 : f <= 2 ? sb2[d] : sb4[d], (e / 4) % 4, e % 16 == 0);
        end
        push(k, 2, 8'h01 << (((k - 1) / 2) % 8), 8'h3F, (k / 2) % 8, k % 16 == 0);
        push(k, 3, 8'h01, k <= 2 ? 8'h3F : 8'h6D, 0, k % 2 == 0);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missed i%0d cyc%0d: checked at %0d, required at %0d", e.inst, e.cyc, cyc, e.cyc);
            end else check_now(e.inst, e.an, e.sg, e.sel, e.fd, $sformatf("cyc%0d", e.cyc));
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check_now(0, 8'h0F, 8'hFF, 0, 1'b0, "reset");
        check_now(1, 8'h0F, 8'hFF, 0, 1'b0, "reset");
        check_now(2, 8'h00, 8'h00, 0, 1'b0, "reset");
        check_now(3, 8'h00, 8'h00, 0, 1'b0, "reset");
        #1 rst = 1'b0;
        #1 run = 1'b1;
        for (int c = 0; c < 74; c++) begin
            expect_cycle(c + 1);
            if (c == 21) a_data = 16'h8888;
            if (c == 34) begin b_en = 1'b0; b_data = 16'hABCD; end
            if (c == 44) b_en = 1'b1;
            @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        check_now(0, 8'h0F, 8'hFF, 0, 1'b0, "async_rst");
        check_now(1, 8'h0F, 8'hFF, 0, 1'b0, "async_rst");
        check_now(2, 8'h00, 8'h00, 0, 1'b0, "async_rst");
        check_now(3, 8'h00, 8'h00, 0, 1'b0, "async_rst");
        run = 1'b0;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
